// File: rtl/median3x3_core.sv
// 3x3 median responder: captures a window under a 4-phase handshake,
// sorts it with a 9-pass odd-even transposition network, returns r[4].
module median3x3_core #(
  parameter int DATA_W   = 8,
  parameter int N_TAPS   = 9,
  parameter int N_PASSES = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i_0,
  input  logic [DATA_W-1:0] data_i_1,
  input  logic [DATA_W-1:0] data_i_2,
  input  logic [DATA_W-1:0] data_i_3,
  input  logic [DATA_W-1:0] data_i_4,
  input  logic [DATA_W-1:0] data_i_5,
  input  logic [DATA_W-1:0] data_i_6,
  input  logic [DATA_W-1:0] data_i_7,
  input  logic [DATA_W-1:0] data_i_8,
  output logic [DATA_W-1:0] data_o,
  output logic              sonuc_done,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        pass_q, pass_d;
  logic [DATA_W-1:0] r_q [N_TAPS];
  logic [DATA_W-1:0] r_d [N_TAPS];
  logic [DATA_W-1:0] net [N_TAPS];
  logic [DATA_W-1:0] din [N_TAPS];
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tmp;

  assign din[0] = data_i_0;
  assign din[1] = data_i_1;
  assign din[2] = data_i_2;
  assign din[3] = data_i_3;
  assign din[4] = data_i_4;
  assign din[5] = data_i_5;
  assign din[6] = data_i_6;
  assign din[7] = data_i_7;
  assign din[8] = data_i_8;

  // Pairs starting at an index with the pass parity are disjoint,
  // so exchanging them in sequence equals a parallel pass.
  always_comb begin
    net = r_q;
    tmp = '0;
    for (int k = 0; k < N_TAPS - 1; k++) begin
      if (1'(k) == pass_q[0] && net[k] > net[k+1]) begin
        tmp      = net[k];
        net[k]   = net[k+1];
        net[k+1] = tmp;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    r_d     = r_q;
    data_d  = data_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          r_d     = din;
          pass_d  = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        r_d = net;
        if (pass_q == 4'(N_PASSES - 1)) begin
          data_d  = net[4];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          pass_d = pass_q + 4'd1;
        end
      end
      DONE: begin
        if (!en_i) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pass_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      data_q  <= data_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign data_o     = data_q;
  assign sonuc_done = done_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_median3x3_core.sv
// Self-checking bench for median3x3_core: vector table, corner
// sequences and random windows against a rank-counting median model.
module tb_median3x3_core;

  typedef logic [8:0][7:0] pix_t;
  typedef struct {
    pix_t  pix;
    int    exp;
    int    hold;
    string nm;
  } vec_t;

  logic       clk_i = 0;
  logic       rst_i = 0;
  logic       en_i  = 0;
  pix_t       d     = '0;
  logic [7:0] data_o;
  logic       sonuc_done;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  median3x3_core dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .data_i_0  (d[0]),
    .data_i_1  (d[1]),
    .data_i_2  (d[2]),
    .data_i_3  (d[3]),
    .data_i_4  (d[4]),
    .data_i_5  (d[5]),
    .data_i_6  (d[6]),
    .data_i_7  (d[7]),
    .data_i_8  (d[8]),
    .data_o    (data_o),
    .sonuc_done(sonuc_done),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic pix_t mk(int a0, int a1, int a2, int a3, int a4,
                              int a5, int a6, int a7, int a8);
    pix_t r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
    r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
    r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
    return r;
  endfunction

  // Median = the value with at most 4 strictly smaller and at least
  // 5 smaller-or-equal entries in the window.
  function automatic int med_ref(pix_t p);
    int lt, le;
    for (int i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (p[j] < p[i]) lt++;
        if (p[j] <= p[i]) le++;
      end
      if (lt <= 4 && le >= 5) return int'(p[i]);
    end
    return -1;
  endfunction

  function automatic pix_t rnd_pix(int mode);
    pix_t r;
    for (int i = 0; i < 9; i++)
      r[i] = (mode == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 85);
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Full handshake: raise en_i, wait for result, hold, release.
  task automatic req(pix_t p, int exp, int hold, string nm);
    int   lat;
    bit   seen;
    int   unstable;
    logic [7:0] prev;
    @(negedge clk_i);
    prev     = data_o;
    unstable = 0;
    d        = p;
    en_i     = 1;
    lat      = -1;
    seen     = 0;
    while (!seen && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (lat == 0) chk({nm, " busy_sort"}, int'(busy_o), 1);
      if (sonuc_done) seen = 1;
      else if (data_o != prev) unstable++;
    end
    chk({nm, " latency"}, lat, 9);
    chk({nm, " prev_held"}, unstable, 0);
    chk({nm, " median"}, int'(data_o), exp);
    if (!seen) begin
      en_i = 0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({nm, " done_held"}, int'(sonuc_done), 1);
      chk({nm, " busy_held"}, int'(busy_o), 1);
    end
    en_i = 0;
    @(negedge clk_i);
    chk({nm, " done_fall"}, int'(sonuc_done), 0);
    chk({nm, " busy_fall"}, int'(busy_o), 0);
    chk({nm, " data_kept"}, int'(data_o), exp);
  endtask

  vec_t tbl [5];
  int   cnt;
  pix_t rp;

  initial begin
    tbl[0] = '{mk(9,8,7,6,5,4,3,2,1), 5, 3, "descend"};
    tbl[1] = '{mk(0,255,0,255,0,255,0,255,128), 128, 0, "alt_ext"};
    tbl[2] = '{mk(200,200,200,200,200,200,200,200,200), 200, 1, "all200"};
    tbl[3] = '{mk(255,255,255,255,0,0,0,0,0), 0, 2, "four255"};
    tbl[4] = '{mk(1,2,3,4,5,6,7,8,9), 5, 0, "ascend"};

    // Reset hold with an active request
    d    = rnd_pix(0);
    en_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst data", int'(data_o), 0);
      chk("rst done", int'(sonuc_done), 0);
      chk("rst busy", int'(busy_o), 0);
    end
    en_i  = 0;
    rst_i = 1;
    @(negedge clk_i);
    chk("rst no_capture", int'(busy_o), 0);

    foreach (tbl[i]) req(tbl[i].pix, tbl[i].exp, tbl[i].hold, tbl[i].nm);

    // Inputs and en_i churn during SORT
    @(negedge clk_i);
    d    = mk(1,2,3,4,5,6,7,8,9);
    en_i = 1;
    cnt  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_i);
      if (sonuc_done) cnt++;
      if (i == 10) chk("churn median", int'(data_o), 5);
      if (i == 1) d = '1;
      if (i <= 8) en_i = (i % 2 == 1);
      else en_i = 0;
    end
    chk("churn done_cycles", cnt, 1);
    chk("churn idle", int'(busy_o), 0);

    // Reset in the middle of a sort
    @(negedge clk_i);
    d    = mk(9,9,9,9,9,9,9,9,9);
    en_i = 1;
    cnt  = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk_i);
      if (sonuc_done) cnt++;
      if (i == 4) rst_i = 0;
      if (i == 6) begin
        rst_i = 1;
        en_i  = 0;
      end
    end
    chk("abort no_done", cnt, 0);
    chk("abort data", int'(data_o), 0);
    chk("abort busy", int'(busy_o), 0);
    req(mk(10,50,30,20,40,90,70,60,80), 50, 0, "post_rst");

    // Back-to-back: release immediately, re-request two cycles later
    req(mk(3,3,3,1,1,1,2,2,2), 2, 0, "b2b");

    for (int n = 0; n < 40; n++) begin
      rp = rnd_pix(n % 2);
      req(rp, med_ref(rp), int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
